reg_scan_monitor: RTL and testbench
===================================

# reg_scan_monitor

Synthesizable debug monitor for the single-cycle MIPS top. It drives the processor's register-display port (`dispSel` out, `dispDat` in) and does two jobs. In sweep mode it reads registers 0..31 in order and streams each {index, value} pair over a valid/ready interface, for a UART or LED formatter downstream. In watch mode it continuously compares one selected register against a target value and raises a sticky `match` flag. This is the hardware counterpart of the bench-side display check.

## Interface

Parameters:
- `SEL_W`, 5: register-select width (32 registers).
- `DATA_W`, 32: register data width.
- `SETTLE`, 1: cycles between a `dispSel` change and sampling `dispDat`. Legal range 1..15.

Ports:
- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `start` in 1: one-cycle pulse; begins a sweep when idle.
- `watch_en` in 1: enables watch-mode comparison while idle.
- `watch_sel` in SEL_W: register index to watch.
- `watch_val` in DATA_W: target value for the watched register.
- `dispSel` out SEL_W: register-select to the processor display port (registered).
- `dispDat` in DATA_W: register contents returned by the processor.
- `out_valid` out 1: a sweep sample is presented.
- `out_ready` in 1: the downstream side accepts the sample.
- `out_idx` out SEL_W: register index of the presented sample.
- `out_data` out DATA_W: register value of the presented sample.
- `busy` out 1: a sweep is in progress.
- `match` out 1: sticky watch hit.

## Operation

- States: IDLE, SETTLE, SEND.
- **IDLE**
  - `busy`=0, `out_valid`=0.
  - If `watch_en`=1, `dispSel` follows `watch_sel`, registered one cycle late.
  - `start`=1 moves to SETTLE. On that edge: `idx`=0, `dispSel`=0, settle counter=0.
- **SETTLE**
  - Settle counter increments each cycle.
  - When the counter reaches SETTLE-1, the next edge latches `out_data`=`dispDat` and `out_idx`=`idx`, sets `out_valid`=1, and moves to SEND.
- **SEND**
  - `out_valid`, `out_idx` and `out_data` are held stable until a cycle with `out_valid`&&`out_ready`.
  - On that handshake edge:
    - If `idx`==31: go to IDLE and clear `out_valid`.
    - Otherwise: `idx`+1, `dispSel`=`idx`+1, settle counter=0, clear `out_valid`, go to SETTLE.
- `start` is ignored while `busy`=1; a sweep is never restarted or aborted by `start`.
- **Watch qualification**
  - A stability counter clears whenever `dispSel` changes, `watch_en`=0, or the state is not IDLE.
  - It saturates at SETTLE.
  - A compare is valid only when the counter equals SETTLE.
- **Match**
  - Sets when `watch_en`=1, the compare is valid, and `dispDat`==`watch_val`. Full DATA_W equality, unsigned.
  - Once set, stays set through sweeps.
  - Cleared only by `reset` or by `watch_en` going low. When `watch_en` is deasserted, `match` is 0 on the next edge.
- `idx` never wraps: the sweep terminates at 31.

## Timing

- Reset values: `dispSel`=0, `out_valid`=0, `out_idx`=0, `out_data`=0, `busy`=0, `match`=0, state=IDLE, all counters 0. The reset takes effect immediately, without waiting for a clock edge.
- Reset during a sweep aborts it. No partial handshake completes, and `out_valid` drops asynchronously.
- `start` sampled at edge k gives `busy`=1 and `dispSel`=0 after edge k. The first `out_valid` rises after edge k+SETTLE.
- Per-register cost with `out_ready` held high is SETTLE+1 cycles. A full sweep is 32·(SETTLE+1) cycles from the `start` edge to `busy`=0.
- `busy` deasserts on the same edge that accepts index 31.
- The earliest `match` is SETTLE+1 edges after `dispSel` settles to `watch_sel`, with `dispDat` equal to target throughout.
- A `watch_sel` change mid-stability restarts qualification, so a stale `dispDat` never produces a match.
- When `start` and a qualifying compare occur on the same edge, the match is still recorded, and the state moves to SETTLE.

## Test plan

- **Reset.** Assert `reset` mid-cycle with `start` held. Required: all outputs 0 immediately; after release, `busy`=0 until a new `start`.
- **Full sweep.** `out_ready`=1, SETTLE=1, registers loaded with value = 100+index; pulse `start`. Required: 32 handshakes with `out_idx` 0..31 and `out_data` 100..131 in order; `busy` high for exactly 64 cycles.
- **Backpressure.** Hold `out_ready`=0 for 5 cycles at index 7. Required: `out_valid`, `out_idx`=7 and `out_data` stay stable; after release, index 8 follows SETTLE+1 cycles later.
- **Watch hit.** `watch_en`=1, `watch_sel`=16, `watch_val`=24; run a program that writes 24 to $16. Required: `match` rises SETTLE+1 cycles after `dispDat`=24 and stays high through a subsequent sweep.
- **Watch stale guard.** Register 3 holds 24 and register 16 holds 5, with `watch_val`=24; switch `watch_sel` from 3 to 16. Required: `match` stays 0. Deasserting `watch_en` after a hit clears `match` on the next edge.
- **Ignored start / mid-sweep reset.** Pulse `start` at index 10. Required: no restart; the sequence continues from 11. Assert `reset` at index 20. Required: `out_valid`=0 and `busy`=0; a new `start` begins again at index 0.

Source files
------------

// File: rtl/reg_scan_monitor.sv
// reg_scan_monitor: debug monitor on the MIPS register-display port.
// Sweep mode streams {index, value} for registers 0..31 over valid/ready.
// Watch mode qualifies one register against a target and sets a sticky match.
//
// state    | meaning
// S_IDLE   | no sweep; dispSel may follow watch_sel for the watch compare
// S_SETTLE | dispSel just changed; waiting SETTLE cycles for dispDat
// S_SEND   | sample presented on out_*, waiting for out_ready
module reg_scan_monitor #(
  parameter int SEL_W  = 5,
  parameter int DATA_W = 32,
  parameter int SETTLE = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              watch_en,
  input  logic [SEL_W-1:0]  watch_sel,
  input  logic [DATA_W-1:0] watch_val,
  output logic [SEL_W-1:0]  dispSel,
  input  logic [DATA_W-1:0] dispDat,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [SEL_W-1:0]  out_idx,
  output logic [DATA_W-1:0] out_data,
  output logic              busy,
  output logic              match
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETTLE = 2'd1,
    S_SEND   = 2'd2
  } state_t;

  localparam logic [SEL_W-1:0] LAST_IDX  = {SEL_W{1'b1}};
  localparam logic [3:0]       SETTLE_C  = 4'(SETTLE);
  localparam logic [3:0]       SETTLE_M1 = 4'(SETTLE - 1);

  state_t             state;
  state_t             state_nxt;
  logic [SEL_W-1:0]   idx;
  logic [SEL_W-1:0]   dispsel_nxt;
  logic [3:0]         settle_cnt;
  logic [3:0]         stab_cnt;
  logic               launch;
  logic               capture;
  logic               accept;
  logic               advance;
  logic               cmp_valid;

  assign busy      = (state != S_IDLE);
  assign advance   = accept && (idx != LAST_IDX);
  assign cmp_valid = (stab_cnt == SETTLE_C);

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // Next-state decode and one-cycle strobes for the datapath.
  always_comb begin
    state_nxt = state;
    launch    = 1'b0;
    capture   = 1'b0;
    accept    = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          state_nxt = S_SETTLE;
          launch    = 1'b1;
        end
      end
      S_SETTLE: begin
        if (settle_cnt == SETTLE_M1) begin
          state_nxt = S_SEND;
          capture   = 1'b1;
        end
      end
      S_SEND: begin
        if (out_valid && out_ready) begin
          accept    = 1'b1;
          state_nxt = (idx == LAST_IDX) ? S_IDLE : S_SETTLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Display select: sweep position while busy, watched register while idle.
  always_comb begin
    dispsel_nxt = dispSel;
    if (launch)                         dispsel_nxt = '0;
    else if (advance)                   dispsel_nxt = idx + 1'b1;
    else if (state == S_IDLE && watch_en) dispsel_nxt = watch_sel;
  end

  // Sweep datapath: index, settle timer, output sample register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idx        <= '0;
      settle_cnt <= '0;
      dispSel    <= '0;
      out_valid  <= 1'b0;
      out_idx    <= '0;
      out_data   <= '0;
    end else begin
      dispSel <= dispsel_nxt;
      if (launch) begin
        idx        <= '0;
        settle_cnt <= '0;
      end else if (advance) begin
        idx        <= idx + 1'b1;
        settle_cnt <= '0;
      end else if (state == S_SETTLE) begin
        settle_cnt <= settle_cnt + 1'b1;
      end
      if (capture) begin
        out_valid <= 1'b1;
        out_idx   <= idx;
        out_data  <= dispDat;
      end else if (accept) begin
        out_valid <= 1'b0;
      end
    end
  end

  // Watch qualification: dispDat is trusted only after dispSel has been
  // steady for SETTLE idle cycles, so a stale value never matches.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stab_cnt <= '0;
    end else if (!watch_en || state != S_IDLE || dispsel_nxt != dispSel) begin
      stab_cnt <= '0;
    end else if (!cmp_valid) begin
      stab_cnt <= stab_cnt + 1'b1;
    end
  end

  // Sticky match, dropped only by reset or watch_en going low.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                                        match <= 1'b0;
    else if (!watch_en)                               match <= 1'b0;
    else if (cmp_valid && dispDat == watch_val)       match <= 1'b1;
  end

endmodule

// File: tb/tb_reg_scan_monitor.sv
// Bench for reg_scan_monitor: a behavioural register file drives dispDat,
// sweeps are scored against the register array, watch vectors from a table.
module tb_reg_scan_monitor;

  localparam int SEL_W  = 5;
  localparam int DATA_W = 32;
  localparam int SETTLE = 1;

  logic              clk;
  logic              reset;
  logic              start;
  logic              watch_en;
  logic [SEL_W-1:0]  watch_sel;
  logic [DATA_W-1:0] watch_val;
  logic [SEL_W-1:0]  dispSel;
  logic [DATA_W-1:0] dispDat;
  logic              out_valid;
  logic              out_ready;
  logic [SEL_W-1:0]  out_idx;
  logic [DATA_W-1:0] out_data;
  logic              busy;
  logic              match;

  logic [DATA_W-1:0] regs [32];
  assign dispDat = regs[dispSel];

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [SEL_W-1:0]  sel;
    logic [DATA_W-1:0] val;
    logic [DATA_W-1:0] regval;
    logic              exp;
  } wvec_t;
  wvec_t wtab [7];

  reg_scan_monitor #(.SEL_W(SEL_W), .DATA_W(DATA_W), .SETTLE(SETTLE)) dut (
    .clk(clk), .reset(reset), .start(start), .watch_en(watch_en),
    .watch_sel(watch_sel), .watch_val(watch_val), .dispSel(dispSel),
    .dispDat(dispDat), .out_valid(out_valid), .out_ready(out_ready),
    .out_idx(out_idx), .out_data(out_data), .busy(busy), .match(match)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Drives one sweep from a negedge. Model: handshakes carry indices 0..31 in
  // order with regs[i]; each launch edge is followed by exactly SETTLE low
  // out_valid cycles; a stalled sample holds still.
  task automatic run_sweep(input int ready_pct, input int stall_idx, input int stall_len,
                           input int poke_idx, input int abort_idx);
    int exp_idx = 0;
    int low_run = 0;
    int busy_cyc = 0;
    int stall_left = stall_len;
    int budget = 3000;
    bit prev_valid = 0;
    bit held = 0;
    bit done = 0;
    bit poked = 0;
    logic [SEL_W-1:0]  h_idx = '0;
    logic [DATA_W-1:0] h_data = '0;
    start = 1;
    @(negedge clk);
    start = 0;
    while (!done) begin
      if (budget == 0) begin
        total++;
        bad++;
        $display("FAIL sweep_timeout actual=%0d required=32", exp_idx);
        break;
      end
      budget--;
      if (!busy) begin
        check("sweep_len", exp_idx, 32);
        if (ready_pct == 100 && stall_len == 0)
          check("busy_cycles", busy_cyc, 32 * (SETTLE + 1));
        done = 1;
      end else begin
        busy_cyc++;
        if (exp_idx == 32) check("busy_late", busy, 0);
        if (held) begin
          check("hold_valid", out_valid, 1);
          check("hold_idx", out_idx, h_idx);
          check("hold_data", out_data, h_data);
        end
        if (out_valid && !prev_valid) begin
          check("settle_gap", low_run, SETTLE);
          check("sample_idx", out_idx, exp_idx);
          check("sample_data", out_data, regs[exp_idx]);
          check("dispsel", dispSel, exp_idx);
          low_run = 0;
        end
        if (!out_valid) low_run++;
        prev_valid = out_valid;
        if (out_valid && exp_idx == abort_idx) begin
          #2 reset = 1;
          #1;
          check("abort_valid", out_valid, 0);
          check("abort_busy", busy, 0);
          check("abort_dispsel", dispSel, 0);
          @(negedge clk);
          reset = 0;
          done = 1;
        end else begin
          if (out_valid && int'(out_idx) == stall_idx && stall_left > 0) begin
            out_ready = 0;
            stall_left--;
          end else begin
            out_ready = ($urandom_range(99) < ready_pct);
          end
          held = out_valid && !out_ready;
          if (held) begin
            h_idx  = out_idx;
            h_data = out_data;
          end
          if (out_valid && out_ready) exp_idx++;
          if (!poked && out_valid && int'(out_idx) == poke_idx) begin
            start = 1;
            poked = 1;
          end
          @(negedge clk);
          start = 0;
        end
      end
    end
    out_ready = 0;
  endtask

  initial begin
    clk = 0; reset = 1; start = 0; watch_en = 0; watch_sel = '0; watch_val = '0;
    out_ready = 0;
    for (int i = 0; i < 32; i++) regs[i] = 32'(100 + i);
    wtab[0] = '{5'd5,  32'h0000_0000, 32'h0000_0000, 1'b1};
    wtab[1] = '{5'd31, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1};
    wtab[2] = '{5'd31, 32'hFFFF_FFFF, 32'h7FFF_FFFF, 1'b0};
    wtab[3] = '{5'd0,  32'h0000_0001, 32'h0000_0000, 1'b0};
    wtab[4] = '{5'd12, 32'h8000_0001, 32'h8000_0000, 1'b0};
    wtab[5] = '{5'd12, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b1};
    wtab[6] = '{5'd20, 32'h0000_0018, 32'h0000_0018, 1'b1};

    #1;
    check("rst_dispsel", dispSel, 0);
    check("rst_valid", out_valid, 0);
    check("rst_idx", out_idx, 0);
    check("rst_data", out_data, 0);
    check("rst_busy", busy, 0);
    check("rst_match", match, 0);
    repeat (2) @(negedge clk);
    reset = 0;
    @(negedge clk);

    // reset mid-cycle with start held
    start = 1;
    @(posedge clk);
    #2;
    check("start_busy", busy, 1);
    reset = 1;
    #1;
    check("midrst_busy", busy, 0);
    check("midrst_valid", out_valid, 0);
    check("midrst_dispsel", dispSel, 0);
    check("midrst_match", match, 0);
    @(negedge clk);
    @(negedge clk);
    start = 0;
    reset = 0;
    repeat (3) begin
      @(negedge clk);
      check("idle_after_reset", busy, 0);
    end

    // full sweep, backpressure, ignored start plus mid-sweep reset, restart
    run_sweep(100, -1, 0, -1, -1);
    run_sweep(100, 7, 5, -1, -1);
    run_sweep(100, -1, 0, 10, 20);
    repeat (2) begin
      @(negedge clk);
      check("post_abort_busy", busy, 0);
      check("post_abort_valid", out_valid, 0);
    end
    run_sweep(100, -1, 0, -1, -1);

    // watch vectors
    for (int t = 0; t < 7; t++) begin
      watch_en = 0;
      @(negedge clk);
      check("wtab_clear", match, 0);
      regs[wtab[t].sel] = wtab[t].regval;
      watch_sel = wtab[t].sel;
      watch_val = wtab[t].val;
      watch_en  = 1;
      repeat (SETTLE + 3) @(negedge clk);
      check("wtab_match", match, wtab[t].exp);
    end

    // watch hit latency, stickiness through a sweep
    watch_en = 0;
    @(negedge clk);
    regs[16] = 32'd24; regs[2] = 32'd7;
    watch_sel = 5'd2; watch_val = 32'd24; watch_en = 1;
    repeat (SETTLE + 3) @(negedge clk);
    check("hit_other", match, 0);
    watch_sel = 5'd16;
    for (int i = 1; i <= SETTLE + 2; i++) begin
      @(negedge clk);
      check("hit_latency", match, (i == SETTLE + 2));
    end
    run_sweep(100, -1, 0, -1, -1);
    check("hit_sticky", match, 1);

    // compare qualifying on the start edge is still recorded
    watch_en = 0;
    @(negedge clk);
    check("clear_next_edge", match, 0);
    regs[5] = 32'h55; watch_sel = 5'd5; watch_val = 32'h55; watch_en = 1;
    for (int i = 0; i < SETTLE + 1; i++) begin
      @(negedge clk);
      check("same_edge_pre", match, 0);
    end
    run_sweep(100, -1, 0, -1, -1);
    check("same_edge_match", match, 1);

    // stale guard: switch away from a matching register before it qualifies
    watch_en = 0;
    @(negedge clk);
    regs[3] = 32'd24; regs[16] = 32'd5; regs[0] = 32'd0;
    watch_val = 32'd24; watch_sel = 5'd0; watch_en = 1;
    @(negedge clk);
    watch_sel = 5'd3;
    @(negedge clk);
    watch_sel = 5'd16;
    repeat (SETTLE + 4) begin
      @(negedge clk);
      check("stale_guard", match, 0);
    end
    watch_sel = 5'd3;
    repeat (SETTLE + 3) @(negedge clk);
    check("stale_then_hit", match, 1);
    watch_en = 0;
    @(negedge clk);
    check("watch_off_clear", match, 0);

    // randomized sweeps with random backpressure and stray start pulses
    for (int r = 0; r < 4; r++) begin
      for (int i = 1; i < 32; i++) regs[i] = $urandom;
      regs[0] = 32'd0;
      run_sweep(int'($urandom_range(90, 40)), int'($urandom_range(31)),
                int'($urandom_range(4)), int'($urandom_range(31)), -1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
